button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Conditions a raw, bouncing mechanical push-button into clean clock-synchronous events.
//  - Drives the downstream on/off toggle logic with a debounced level and one-cycle press/release pulses.
//  - Provides the toggled light state itself, so no logic is ever clocked by the raw button.
//  - Sits between the board pin and any user-interface logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive cycles a new level must persist before acceptance (10 ms @ 100 MHz); >=2
//  CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  LONG_CYCLES      50_000_000 cycles held before long_press fires (used only with BTN_LONG_PRESS_EN)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  btn_raw        in   1  raw button pin, asynchronous, active-high, may bounce
//  btn_level      out  1  debounced button level
//  press_pulse    out  1  one-cycle pulse on accepted 0->1
//  release_pulse  out  1  one-cycle pulse on accepted 1->0
//  light          out  1  toggles on every press_pulse
//  long_press     out  1  one-cycle pulse after long hold (tied 0 without macro)
// BEHAVIOUR
//  - Reset: sync flops, counter, btn_level, press_pulse, release_pulse, light and long_press are all 0; state IDLE_LOW.
//  - Synchronizer: 2-flop chain on btn_raw gives btn_s. Latency is 2 clk edges.
//  - FSM states:
//    - IDLE_LOW: btn_s=1 -> WAIT_HIGH, cnt=1.
//    - WAIT_HIGH: btn_s=0 -> IDLE_LOW, cnt=0 (bounce rejected). cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> STABLE_HIGH. Otherwise cnt++.
//    - STABLE_HIGH: btn_s=0 -> WAIT_LOW, cnt=1.
//    - WAIT_LOW: mirror of WAIT_HIGH -> STABLE_HIGH on bounce, -> IDLE_LOW on acceptance.
//  - Outputs are registered.
//    - btn_level, press_pulse and light update in the cycle the FSM enters STABLE_HIGH.
//    - btn_level and release_pulse update in the cycle it enters IDLE_LOW.
//  - Latency: a clean raw edge produces its pulse DEBOUNCE_CYCLES+2 edges later.
//  - Pulses are exactly 1 cycle wide. press_pulse and release_pulse are never asserted together.
//  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse and no level change. The counter restarts from 0 on every reversal.
//  - The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
//  - light flips only on press_pulse; release has no effect on it.
//  - Reset asserted mid-debounce or mid-hold drops all state immediately. A button still held after reset release is re-debounced and yields a fresh press_pulse.
// CONFIGURATION
//  - BTN_LONG_PRESS_EN defined:
//    - hold counter counts while in STABLE_HIGH;
//    - long_press pulses once when it reaches LONG_CYCLES-1, then saturates;
//    - the hold counter clears on leaving STABLE_HIGH; one long_press per press.
//  - BTN_LONG_PRESS_EN undefined: no hold counter is built; long_press is constant 0.
// STRUCTURE
//  - Package btn_pkg: state enum (IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW) and default DEBOUNCE_CYCLES/LONG_CYCLES constants.
//  - Sub-module sync_2ff: generic 2-flop synchronizer, async active-low reset to 0.
//  - FSM, counter and output registers live in button_debounce.
// TESTING (DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
//  1. Reset is held, btn_raw=1 -> all outputs 0. After release, press_pulse is seen at edge 10 and light=1.
//  2. Clean press, raw 0->1 held 20 cycles -> single press_pulse 10 edges after the edge; btn_level=1; light=1.
//  3. Bounce, raw high 5 cycles, low 2, high 5, low -> no pulses; btn_level and light stay 0.
//  4. Release after a stable press -> one release_pulse 10 edges later; btn_level=0; light unchanged at 1.
//  5. Two full press/release cycles -> light goes 0->1->0; exactly 2 press_pulse and 2 release_pulse.
//  6. BTN_LONG_PRESS_EN, hold 60 cycles -> one long_press 32 cycles after press_pulse, none after that. Without the macro long_press stays 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// The debouncer FSM states are declared here; the top imports this package.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      STABLE_HIGH,
      WAIT_LOW
   } btn_state_t;

   // 10 ms and 500 ms at 100 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEFAULT_LONG_CYCLES     = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Both stages reset asynchronously to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking so each stage samples the previous stage's old value.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release pulses and light toggle.
// Define BTN_LONG_PRESS_EN to build the hold counter that drives long_press.
module button_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic light,
   output logic long_press
);

   if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
      $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
   end
   if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_debounce: LONG_CYCLES must be >= 2");
   end

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_s;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept_high, accept_low;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (btn_raw),
      .q    (btn_s)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept_high = 1'b0;
      accept_low  = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            if (btn_s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!btn_s) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = STABLE_HIGH;
               cnt_d       = '0;
               accept_high = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!btn_s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (btn_s) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = IDLE_LOW;
               cnt_d      = '0;
               accept_low = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE_LOW;
         cnt_q         <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         light         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         press_pulse   <= accept_high;
         release_pulse <= accept_low;
         if (accept_high) begin
            btn_level <= 1'b1;
            light     <= ~light;
         end else if (accept_low) begin
            btn_level <= 1'b0;
         end
      end
   end

`ifdef BTN_LONG_PRESS_EN
   localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] hold_q;
   logic              long_done_q;
   logic              long_q;
   logic              long_fire;

   // The pulse fires in the cycle after the saturated count is first seen.
   assign long_fire = (state_q == STABLE_HIGH) && (hold_q == HOLD_LAST) && !long_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else if (state_q == STABLE_HIGH) begin
         if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + HOLD_ONE;
         end
         long_q <= long_fire;
         if (long_fire) begin
            long_done_q <= 1'b1;
         end
      end else begin
         hold_q      <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

endmodule
